// File: rtl/md_unit_pkg.sv
// Shared MD operation encodings, FSM state constants and decode helpers
// for the E-stage multiply/divide unit.
package md_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage MD bus: operation/operands in, start/busy handshake and HI/LO results out.
interface md_unit_if;

    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output md_op, rs_val, rt_val,
        input  start, busy, hi, lo, md_out
    );

    modport slave (
        input  md_op, rs_val, rt_val,
        output start, busy, hi, lo, md_out
    );

endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one MD op.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod;

    // Signed ops work on magnitudes and fix signs afterwards, so one unsigned
    // multiplier/divider serves both flavours (including the -2^31 corner cases).
    always_comb begin
        a_neg       = is_signed_op(md_op) & a[31];
        b_neg       = is_signed_op(md_op) & b[31];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        div_by_zero = is_div(md_op) && (b == '0);
        div_b       = div_by_zero ? 32'd1 : b_mag;
        quo         = a_mag / div_b;
        rem         = a_mag % div_b;
        prod        = {32'b0, a_mag} * {32'b0, b_mag};
        if (a_neg ^ b_neg) begin
            prod = -prod;
        end

        res_hi = '0;
        res_lo = '0;
        case (md_op)
            MD_MULT, MD_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_lo = (a_neg ^ b_neg) ? -quo : quo;
                res_hi = a_neg ? -rem : rem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: holds architectural HI/LO, runs multi-cycle
// mult/div with a busy window, and serves mfhi/mflo/mthi/mtlo.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    md_unit_if.slave   md
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    logic [0:0]  state;
    logic [3:0]  counter;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_skip;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_dz;
    logic        start_w;

    md_calc u_calc (
        .md_op       (md.md_op),
        .a           (md.rs_val),
        .b           (md.rt_val),
        .res_hi      (calc_hi),
        .res_lo      (calc_lo),
        .div_by_zero (calc_dz)
    );

    assign start_w = is_md_start(md.md_op) && (state == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            counter   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_skip <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_w) begin
                        pend_hi   <= calc_hi;
                        pend_lo   <= calc_lo;
                        pend_skip <= calc_dz;
                        counter   <= is_div(md.md_op) ? DIV_LOAD : MULT_LOAD;
                        state     <= ST_RUN;
                    end else if (md.md_op == MD_MTHI) begin
                        hi_q <= md.rs_val;
                    end else if (md.md_op == MD_MTLO) begin
                        lo_q <= md.rs_val;
                    end
                end
                default: begin
                    // Result is committed on the edge that ends the busy window;
                    // a divide by zero still burns the full window but writes nothing.
                    if (counter == '0) begin
                        if (!pend_skip) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        state <= ST_IDLE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
            endcase
        end
    end

    assign md.start = start_w;
    assign md.busy  = (state == ST_RUN);
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

    always_comb begin
        md.md_out = '0;
        case (md.md_op)
            MD_MFHI: md.md_out = hi_q;
            MD_MFLO: md.md_out = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, hand-written
// multi-cycle corner sequences, and randomized ops against an arithmetic model.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    typedef longint unsigned u64_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (rst_n),
        .md    (bus)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    bit          busy_guard = 1'b1;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    vec_t        vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The stall unit must never present an op while the unit is busy.
    always @(negedge clk) begin
        if (busy_guard && rst_n && bus.busy === 1'b1 && bus.md_op !== MD_NONE) begin
            fails++;
            $display("FAIL busy_guard: md_op %0d while busy, required %0d", bus.md_op, MD_NONE);
        end
    end

    // Behavioural reference: HI/LO after an op, from plain integer arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l);
        longint sp, sq, sr;
        u64_t   up;
        case (op)
            MD_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                h  = sp[63:32];
                l  = sp[31:0];
            end
            MD_MULTU: begin
                up = u64_t'(a) * u64_t'(b);
                h  = up[63:32];
                l  = up[31:0];
            end
            MD_DIV: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                l  = sq[31:0];
                h  = sr[31:0];
            end
            MD_DIVU: if (b != 0) begin
                l = a / b;
                h = a % b;
            end
            MD_MTHI: h = a;
            MD_MTLO: l = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int unsigned n;
        bus.md_op  = op;
        bus.rs_val = a;
        bus.rt_val = b;
        #1;
        check({name, ".start"}, {31'b0, bus.start}, {31'b0, is_md_start(op)});
        if (op == MD_MFHI || op == MD_MFLO)
            check({name, ".md_out"}, bus.md_out, (op == MD_MFHI) ? m_hi : m_lo);
        else
            check({name, ".md_out_zero"}, bus.md_out, 32'h0);
        @(posedge clk); #1;
        bus.md_op = MD_NONE;
        n = 0;
        if (is_md_start(op)) n = is_div(op) ? DIV_N : MULT_N;
        for (int unsigned k = 0; k < n; k++) begin
            check({name, ".busy"}, {31'b0, bus.busy}, 32'h1);
            check({name, ".hi_hold"}, bus.hi, m_hi);
            check({name, ".lo_hold"}, bus.lo, m_lo);
            @(posedge clk); #1;
        end
        check({name, ".busy_end"}, {31'b0, bus.busy}, 32'h0);
        check({name, ".hi"}, bus.hi, exp_hi);
        check({name, ".lo"}, bus.lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, eh, el;

        vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MD_DIVU,  32'h7,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{MD_DIVU,  32'hFFFF_FFFF, 32'hA,         32'h0000_0005, 32'h1999_9999};
        vecs[6] = '{MD_MTHI,  32'h1234,      32'h0,         32'h0000_1234, 32'h1999_9999};
        vecs[7] = '{MD_MTLO,  32'hABCD,      32'h5,         32'h0000_1234, 32'h0000_ABCD};
        vecs[8] = '{MD_DIV,   32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{MD_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};

        bus.md_op  = MD_NONE;
        bus.rs_val = '0;
        bus.rt_val = '0;
        m_hi = '0;
        m_lo = '0;

        #2;
        check("reset.busy", {31'b0, bus.busy}, 32'h0);
        check("reset.hi", bus.hi, 32'h0);
        check("reset.lo", bus.lo, 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);
        end
        run_op("mfhi", MD_MFHI, 32'h0, 32'h0, m_hi, m_lo);
        run_op("mflo", MD_MFLO, 32'h0, 32'h0, m_hi, m_lo);

        // mult held on md_op throughout the busy window: no restart, exact N-cycle completion
        busy_guard = 1'b0;
        bus.md_op  = MD_MULT;
        bus.rs_val = 32'h2;
        bus.rt_val = 32'h3;
        #1;
        check("held.start", {31'b0, bus.start}, 32'h1);
        @(posedge clk); #1;
        for (int unsigned k = 0; k < MULT_N; k++) begin
            check("held.busy", {31'b0, bus.busy}, 32'h1);
            check("held.no_start", {31'b0, bus.start}, 32'h0);
            @(posedge clk); #1;
        end
        check("held.busy_end", {31'b0, bus.busy}, 32'h0);
        check("held.hi", bus.hi, 32'h0);
        check("held.lo", bus.lo, 32'h6);
        check("held.restart_ready", {31'b0, bus.start}, 32'h1);
        bus.md_op = MD_NONE;
        busy_guard = 1'b1;
        m_hi = 32'h0;
        m_lo = 32'h6;

        // async reset during busy cycle 3 of a div discards it
        bus.md_op  = MD_DIV;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        @(posedge clk); #1;
        bus.md_op = MD_NONE;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid.busy", {31'b0, bus.busy}, 32'h0);
        check("rst_mid.hi", bus.hi, 32'h0);
        check("rst_mid.lo", bus.lo, 32'h0);
        #3 rst_n = 1'b1;
        repeat (DIV_N + 2) @(posedge clk);
        #1;
        check("rst_after.busy", {31'b0, bus.busy}, 32'h0);
        check("rst_after.hi", bus.hi, 32'h0);
        check("rst_after.lo", bus.lo, 32'h0);
        m_hi = '0;
        m_lo = '0;

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(1, 8));
            a  = pick();
            b  = pick();
            eh = m_hi;
            el = m_lo;
            model(op, a, b, eh, el);
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, eh, el);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
